fp16_fma_sched: RTL and testbench

//  Shares one pipelined FP16 FMA unit (out = a*b + c, fixed latency, no stall) among N requesters.

---
 rtl/fp16_fma_sched_pkg.sv | 18 +
 rtl/fp16_fma_sched_if.sv | 29 ++
 rtl/fp16_fma_sched_rsp_fifo.sv | 50 +++++
 rtl/fp16_fma_sched.sv | 175 +++++++++++++++++
 tb/tb_fp16_fma_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp16_fma_sched_pkg.sv
// Shared types for the FP16 FMA scheduler: FP16 word, requester id and
// the {valid, id} tag that rides alongside each operation in the FMA pipe.
package fma_sched_pkg;

  localparam int FP16_W  = 16;
  // Requester ids are sized for the largest supported requester count (8).
  localparam int MAX_REQ = 8;
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef logic [FP16_W-1:0] fp16_t;
  typedef logic [ID_W-1:0]   req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/fp16_fma_sched_if.sv
// Requester-side bus of the FP16 FMA scheduler: per-requester operand
// handshake and per-requester result handshake, FP16 slices packed by index.
interface fp16_fma_sched_if #(
  parameter int N_REQ = 4
);
  import fma_sched_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [FP16_W*N_REQ-1:0] req_a;
  logic [FP16_W*N_REQ-1:0] req_b;
  logic [FP16_W*N_REQ-1:0] req_c;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [FP16_W*N_REQ-1:0] rsp_data;

  // Operand sequencers side.
  modport master (
    output req_valid, req_a, req_b, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/fp16_fma_sched_rsp_fifo.sv
// Single-clock response FIFO of FP16 results with a valid/ready read side.
// Overflow cannot happen when the writer reserves space ahead of time; the
// assertion below catches a write into a full FIFO if that ever breaks.
module fma_rsp_fifo
  import fma_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  fp16_t wr_data,
  output logic  rd_valid,
  input  logic  rd_ready,
  output fp16_t rd_data,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  fp16_t        mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_valid = !empty;
  // Storage is not reset, so the head is masked to keep the output at zero when empty.
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Read/write pointers advance on write and on accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_valid && rd_ready) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Result storage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  wr_full_chk: assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/fp16_fma_sched.sv
// Shares one pipelined FP16 FMA (fixed latency, no stall) among N_REQ
// requesters: round-robin issue gated by per-requester credits, requester id
// carried through a tag pipe matched to the FMA latency, results returned
// into per-requester FIFOs. Optional macro FMA_SCHED_PERF_EN adds saturating
// issue and credit-blocked cycle counters.
module fp16_fma_sched
  import fma_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int FMA_LAT   = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  fp16_fma_sched_if.slave bus,
  output logic  fma_in_valid,
  output fp16_t fma_a,
  output fp16_t fma_b,
  output fp16_t fma_c,
  input  logic  fma_out_valid,
  input  fp16_t fma_out,
  output logic  err_orphan
`ifdef FMA_SCHED_PERF_EN
  ,
  output logic [31:0] perf_issue_cnt,
  output logic [31:0] perf_block_cnt
`endif
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  // Credit: in-flight plus queued results per requester.
  logic [CNT_W-1:0] cnt [N_REQ];
  req_id_t          ptr;
  req_id_t          gnt_id;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] pop;
  logic [N_REQ-1:0] wr_en;
  logic [N_REQ-1:0] rsp_vld;
  fp16_t            rsp_dat [N_REQ];
  logic             accept;
  int               idx;

  logic             vld_p0;
  req_id_t          id_p0;
  fp16_t            a_p0, b_p0, c_p0;
  tag_t             tag_p [FMA_LAT];
  tag_t             tag_last;

  function automatic req_id_t next_id(input req_id_t id);
    return (int'(id) == N_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  // A requester may issue only while it holds a free credit.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++)
      elig[i] = bus.req_valid[i] && (cnt[i] < CNT_W'(RSP_DEPTH));
  end

  // Round-robin: first eligible requester at or after ptr, wrapping.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    accept = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!accept && elig[idx]) begin
        grant[idx] = 1'b1;
        gnt_id     = req_id_t'(idx);
        accept     = 1'b1;
      end
    end
  end

  assign bus.req_ready = grant;
  assign pop           = rsp_vld & bus.rsp_ready;

  // ---- p0: accepted operation registered and presented to the FMA ----
  // Arbiter pointer, issue valid, tag pipe, credits and orphan flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      vld_p0     <= 1'b0;
      id_p0      <= '0;
      err_orphan <= 1'b0;
      for (int k = 0; k < FMA_LAT; k++) tag_p[k] <= '0;
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      if (accept) ptr <= next_id(gnt_id);
      vld_p0   <= accept;
      id_p0    <= gnt_id;
      tag_p[0] <= '{valid: vld_p0, id: id_p0};
      for (int k = 1; k < FMA_LAT; k++) tag_p[k] <= tag_p[k-1];
      for (int i = 0; i < N_REQ; i++)
        cnt[i] <= cnt[i] + CNT_W'(grant[i]) - CNT_W'(pop[i]);
      if (fma_out_valid && !tag_last.valid) err_orphan <= 1'b1;
    end
  end

  // Operand capture from the granted slice.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0 <= bus.req_a[FP16_W*gnt_id +: FP16_W];
      b_p0 <= bus.req_b[FP16_W*gnt_id +: FP16_W];
      c_p0 <= bus.req_c[FP16_W*gnt_id +: FP16_W];
    end
  end

  assign fma_in_valid = vld_p0;
  assign fma_a        = vld_p0 ? a_p0 : '0;
  assign fma_b        = vld_p0 ? b_p0 : '0;
  assign fma_c        = vld_p0 ? c_p0 : '0;

  // ---- p1..pFMA_LAT: tag pipe tracks the FMA; last stage steers the result ----
  assign tag_last = tag_p[FMA_LAT-1];

  // Route a tagged result to its requester's FIFO.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < N_REQ; i++)
      wr_en[i] = fma_out_valid && tag_last.valid && (tag_last.id == req_id_t'(i));
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_rsp
    logic full;
    logic empty;

    fma_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[g]),
      .wr_data  (fma_out),
      .rd_valid (rsp_vld[g]),
      .rd_ready (bus.rsp_ready[g]),
      .rd_data  (rsp_dat[g]),
      .full     (full),
      .empty    (empty)
    );

    full_has_no_credit: assert property (@(posedge clk) disable iff (rst)
      full |-> (cnt[g] == CNT_W'(RSP_DEPTH)));
    no_credit_used_empty: assert property (@(posedge clk) disable iff (rst)
      (cnt[g] == '0) |-> empty);
  end

  assign bus.rsp_valid = rsp_vld;

  // Pack per-requester result slices onto the bus.
  always_comb begin
    bus.rsp_data = '0;
    for (int i = 0; i < N_REQ; i++) bus.rsp_data[FP16_W*i +: FP16_W] = rsp_dat[i];
  end

`ifdef FMA_SCHED_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  // Issue count and credit-blocked cycle count, both saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_cnt <= '0;
      perf_block_cnt <= '0;
    end else begin
      perf_issue_cnt <= sat_inc(perf_issue_cnt, accept);
      perf_block_cnt <= sat_inc(perf_block_cnt, (|bus.req_valid) && !accept);
    end
  end
`endif

endmodule

// File: tb/tb_fp16_fma_sched.sv
// Bench for fp16_fma_sched: behavioural FP16 FMA with fixed latency, a
// spec-level model (RR pointer, credits = accepted - popped, per-requester
// result queues) checked every cycle, plus directed scenarios.
module tb_fp16_fma_sched;

  localparam int NR    = 4;
  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fma_in_valid;
  logic [15:0] fma_a, fma_b, fma_c;
  logic        fma_out_valid;
  logic [15:0] fma_out;
  logic        err_orphan;
  logic        force_ov = 1'b0;
`ifdef FMA_SCHED_PERF_EN
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_block_cnt;
`endif

  fp16_fma_sched_if #(.N_REQ(NR)) bus ();

  fp16_fma_sched #(.N_REQ(NR), .FMA_LAT(LAT), .RSP_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .fma_in_valid  (fma_in_valid),
    .fma_a         (fma_a),
    .fma_b         (fma_b),
    .fma_c         (fma_c),
    .fma_out_valid (fma_out_valid),
    .fma_out       (fma_out),
    .err_orphan    (err_orphan)
`ifdef FMA_SCHED_PERF_EN
    ,
    .perf_issue_cnt(perf_issue_cnt),
    .perf_block_cnt(perf_block_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;

  logic [47:0] src  [NR][$];
  logic [15:0] expq [NR][$];
  int          m_cnt [NR];
  int          m_ptr;
  int          acc_cnt [NR];
  bit          prev_acc;
  int          glog [$];
  int          gcyc [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FP16 <-> real for normal numbers and zero; all stimulus values are exact.
  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    if (h[14:10] == 5'd0) return 0.0;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    int   e;
    int   mant;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    if (s) r = -r;
    e = 15;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0) begin r = r * 2.0; e--; end
    mant = int'((r - 1.0) * 1024.0);
    return {s, e[4:0], mant[9:0]};
  endfunction

  function automatic logic [15:0] fp_fma(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    return r2h(h2r(a) * h2r(b) + h2r(c));
  endfunction

  function automatic logic [15:0] i2h(input int v);
    return r2h(real'(v));
  endfunction

  // Behavioural FMA: fixed latency, shares rst, optional forced orphan output.
  logic [LAT-1:0] fv;
  logic [15:0]    fd [LAT];
  always @(posedge clk) begin
    if (rst) fv <= '0;
    else     fv <= {fv[LAT-2:0], fma_in_valid};
    fd[0] <= fp_fma(fma_a, fma_b, fma_c);
    for (int k = 1; k < LAT; k++) fd[k] <= fd[k-1];
  end
  assign fma_out_valid = fv[LAT-1] | force_ov;
  assign fma_out       = force_ov ? 16'h1234 : fd[LAT-1];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Requester driver + per-cycle compare against the model.
  initial begin : drv
    logic [NR-1:0] acc;
    logic [NR-1:0] eg;
    logic [47:0]   op;
    int            idx;
    bit            found;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_c = '0;
    m_ptr = 0;
    prev_acc = 1'b0;
    for (int i = 0; i < NR; i++) begin m_cnt[i] = 0; acc_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      acc = '0;
      if (rst) begin
        m_ptr = 0;
        prev_acc = 1'b0;
        for (int i = 0; i < NR; i++) begin m_cnt[i] = 0; expq[i].delete(); end
      end else begin
        eg = '0;
        found = 1'b0;
        for (int k = 0; k < NR; k++) begin
          idx = (m_ptr + k) % NR;
          if (!found && bus.req_valid[idx] && m_cnt[idx] < DEPTH) begin
            eg[idx] = 1'b1;
            found = 1'b1;
          end
        end
        chk("req_ready", 64'(bus.req_ready), 64'(eg));
        chk("fma_in_valid", 64'(fma_in_valid), 64'(prev_acc));
        for (int i = 0; i < NR; i++) begin
          if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
            if (expq[i].size() == 0) chk($sformatf("rsp_unexpected%0d", i), 64'(1), 64'(0));
            else chk($sformatf("rsp_data%0d", i), 64'(bus.rsp_data[16*i +: 16]), 64'(expq[i].pop_front()));
            m_cnt[i]--;
          end
        end
        acc = bus.req_valid & bus.req_ready;
        for (int i = 0; i < NR; i++) begin
          if (acc[i]) begin
            op = src[i][0];
            expq[i].push_back(fp_fma(op[47:32], op[31:16], op[15:0]));
            m_cnt[i]++;
            m_ptr = (i + 1) % NR;
            acc_cnt[i]++;
            glog.push_back(i);
            gcyc.push_back(cyc_n);
          end
        end
        prev_acc = |acc;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) op = src[i].pop_front();
        if (src[i].size() > 0) begin
          op = src[i][0];
          bus.req_valid[i] = 1'b1;
          bus.req_a[16*i +: 16] = op[47:32];
          bus.req_b[16*i +: 16] = op[31:16];
          bus.req_c[16*i +: 16] = op[15:0];
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_a[16*i +: 16] = '0;
          bus.req_b[16*i +: 16] = '0;
          bus.req_c[16*i +: 16] = '0;
        end
      end
    end
  end

  task automatic pclk();
    @(posedge clk);
    #2;
  endtask

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int r, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    src[r].push_back({a, b, c});
  endtask

  task automatic do_reset();
    pclk();
    rst = 1'b1;
    pclk();
    rst = 1'b0;
  endtask

  function automatic bit busy();
    bit b;
    b = (bus.req_valid != '0) || fma_in_valid;
    for (int i = 0; i < NR; i++) b = b || (src[i].size() != 0) || (expq[i].size() != 0);
    return b;
  endfunction

  task automatic wait_idle(input string name, input int lim);
    int n;
    n = 0;
    nclk();
    while (busy() && n < lim) begin nclk(); n++; end
    chk(name, 64'(busy()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base [NR];
    int n;
    rst = 1'b1;
    bus.rsp_ready = '1;
    repeat (3) pclk();
    nclk();
    // Reset state.
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
    chk("rst_fma_in_valid", 64'(fma_in_valid), 64'(0));
    chk("rst_fma_abc", 64'({fma_a, fma_b, fma_c}), 64'(0));
    chk("rst_err_orphan", 64'(err_orphan), 64'(0));
    // Pin the FP16 model: 1*2+1 = 3, 2*3-1 = 5.
    chk("model_fma_3", 64'(fp_fma(16'h3C00, 16'h4000, 16'h3C00)), 64'(16'h4200));
    chk("model_fma_5", 64'(fp_fma(16'h4000, 16'h4200, 16'hBC00)), 64'(16'h4500));
    pclk();
    rst = 1'b0;

    // 1: single op, result exactly 6 cycles after accept.
    push(0, 16'h3C00, 16'h4000, 16'h3C00);
    n = 0;
    nclk();
    while (!(bus.req_valid[0] && bus.req_ready[0]) && n < 20) begin nclk(); n++; end
    chk("t1_accept_seen", 64'(bus.req_valid[0] && bus.req_ready[0]), 64'(1));
    for (int k = 1; k <= 6; k++) begin
      nclk();
      chk($sformatf("t1_rsp_valid_c%0d", k), 64'(bus.rsp_valid[0]), 64'(k == 6));
      if (k == 6) chk("t1_rsp_data", 64'(bus.rsp_data[15:0]), 64'(16'h4200));
    end
    wait_idle("t1_idle", 50);

    // 2: all requesters stream; RR from 0, one issue per cycle.
    do_reset();
    glog.delete();
    gcyc.delete();
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < NR; i++) push(i, i2h(j + 1), 16'h4000, i2h(i));
    wait_idle("t2_idle", 100);
    chk("t2_grant_count", 64'(glog.size()), 64'(12));
    if (glog.size() >= 12)
      for (int k = 0; k < 12; k++) begin
        chk($sformatf("t2_grant%0d", k), 64'(glog[k]), 64'(k % NR));
        chk($sformatf("t2_cycle%0d", k), 64'(gcyc[k] - gcyc[0]), 64'(k));
      end

    // 3: requester 1 back-pressured; exactly 4 credits, others keep going.
    bus.rsp_ready[1] = 1'b0;
    for (int i = 0; i < NR; i++) base[i] = acc_cnt[i];
    for (int j = 0; j < 8; j++) push(1, i2h(j + 1), 16'h4000, 16'h3C00);
    for (int j = 0; j < 6; j++) begin
      push(0, i2h(j + 2), 16'h4000, 16'h0000);
      push(2, i2h(j + 3), 16'h4000, 16'h4000);
      push(3, i2h(j + 4), 16'h3C00, 16'h4200);
    end
    repeat (35) pclk();
    nclk();
    chk("t3_req1_accepts", 64'(acc_cnt[1] - base[1]), 64'(4));
    chk("t3_req0_accepts", 64'(acc_cnt[0] - base[0]), 64'(6));
    chk("t3_req2_accepts", 64'(acc_cnt[2] - base[2]), 64'(6));
    chk("t3_req3_accepts", 64'(acc_cnt[3] - base[3]), 64'(6));
    chk("t3_req1_blocked", 64'({bus.req_valid[1], bus.req_ready[1]}), 64'(2'b10));
    chk("t3_rsp1_full", 64'(bus.rsp_valid[1]), 64'(1));
    pclk();
    bus.rsp_ready[1] = 1'b1;
    wait_idle("t3_idle", 100);
    chk("t3_req1_total", 64'(acc_cnt[1] - base[1]), 64'(8));

    // 4: reset with three ops in flight.
    push(0, 16'h3C00, 16'h3C00, 16'h3C00);
    push(1, 16'h4000, 16'h4000, 16'h3C00);
    push(2, 16'h4200, 16'h4000, 16'h0000);
    n = 0;
    nclk();
    while ((src[0].size() + src[1].size() + src[2].size()) != 0 && n < 20) begin nclk(); n++; end
    chk("t4_issued", 64'(src[0].size() + src[1].size() + src[2].size()), 64'(0));
    do_reset();
    nclk();
    chk("t4_fma_in_valid", 64'(fma_in_valid), 64'(0));
    chk("t4_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("t4_req_ready", 64'(bus.req_ready), 64'(0));
    for (int k = 0; k < 12; k++) begin
      nclk();
      chk($sformatf("t4_no_rsp%0d", k), 64'({bus.rsp_valid, err_orphan}), 64'(0));
    end
    bus.rsp_ready[2] = 1'b0;
    base[2] = acc_cnt[2];
    for (int j = 0; j < 6; j++) push(2, i2h(j + 1), 16'h3C00, 16'h3C00);
    repeat (15) pclk();
    nclk();
    chk("t4_credits_cleared", 64'(acc_cnt[2] - base[2]), 64'(4));
    pclk();
    bus.rsp_ready[2] = 1'b1;
    wait_idle("t4_idle", 100);

    // 5: forced FMA output with an empty tag pipe.
    pclk();
    force_ov = 1'b1;
    pclk();
    force_ov = 1'b0;
    nclk();
    chk("t5_err_orphan", 64'(err_orphan), 64'(1));
    chk("t5_no_write", 64'(bus.rsp_valid), 64'(0));
    for (int k = 0; k < 5; k++) begin
      nclk();
      chk($sformatf("t5_sticky%0d", k), 64'(err_orphan), 64'(1));
    end
    do_reset();
    nclk();
    chk("t5_err_cleared", 64'(err_orphan), 64'(0));

`ifdef FMA_SCHED_PERF_EN
    // 6: 9 free accepts, then one op blocked for exactly 3 cycles.
    bus.rsp_ready[0] = 1'b0;
    for (int j = 0; j < 4; j++) push(0, i2h(j + 1), 16'h4000, 16'h3C00);
    for (int j = 0; j < 5; j++) push(1, i2h(j + 1), 16'h3C00, 16'h4000);
    repeat (20) pclk();
    push(0, 16'h4200, 16'h4200, 16'h0000);
    n = 0;
    nclk();
    while (!(bus.req_valid[0] && !bus.req_ready[0]) && n < 30) begin nclk(); n++; end
    chk("t6_blocked_seen", 64'(bus.req_valid[0] && !bus.req_ready[0]), 64'(1));
    pclk();
    pclk();
    bus.rsp_ready[0] = 1'b1;
    wait_idle("t6_idle", 100);
    chk("t6_perf_issue", 64'(perf_issue_cnt), 64'(10));
    chk("t6_perf_block", 64'(perf_block_cnt), 64'(3));
`endif

    wait_idle("final_idle", 50);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
